// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction fetch slice: bus widths, FSM encodings,
// instruction-cache geometry and the byte-lane merge helper.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int ByteBus     = 8;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  localparam logic [2:0] B0   = 3'd0;
  localparam logic [2:0] B1   = 3'd1;
  localparam logic [2:0] B2   = 3'd2;
  localparam logic [2:0] B3   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int IcEntries = 16;
  localparam int IcIdxW    = 4;
  localparam int IcTagW    = InstAddrBus - IcIdxW - 2;

  // Byte k of an instruction lives in [31-8k -: 8] (big-endian memory order).
  function automatic logic [InstBus-1:0] put_lane(input logic [InstBus-1:0] w,
                                                  input logic [1:0]         lane,
                                                  input logic [ByteBus-1:0] b);
    logic [InstBus-1:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory bus shared by the fetch unit (master) and the
// memory arbiter (slave).
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   mem_rd_o;
  logic [InstAddrBus-1:0] mem_a_o;
  logic                   mem_grant_i;
  logic [ByteBus-1:0]     mem_din_i;

  modport master (output mem_rd_o, output mem_a_o, input mem_grant_i, input mem_din_i);
  modport slave  (input mem_rd_o, input mem_a_o, output mem_grant_i, output mem_din_i);

endinterface

// File: rtl/if_fetch_icache.sv
// Direct-mapped 16-entry instruction cache: combinational lookup, synchronous
// write. Only instantiated when IF_ICACHE_EN is defined.
module if_icache
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:2] rd_addr,
  output logic                   rd_hit,
  output logic [InstBus-1:0]     rd_data,
  input  logic                   wr_en,
  input  logic [InstAddrBus-1:2] wr_addr,
  input  logic [InstBus-1:0]     wr_data
);

  logic [IcTagW-1:0]    tag_mem  [IcEntries];
  logic [InstBus-1:0]   data_mem [IcEntries];
  logic [IcEntries-1:0] vld;
  logic [IcIdxW-1:0]    rd_idx;
  logic [IcIdxW-1:0]    wr_idx;

  assign rd_idx  = rd_addr[IcIdxW+1:2];
  assign wr_idx  = wr_addr[IcIdxW+1:2];
  assign rd_hit  = vld[rd_idx] && (tag_mem[rd_idx] == rd_addr[InstAddrBus-1:IcIdxW+2]);
  assign rd_data = data_mem[rd_idx];

  // Only the valid bits are reset; tag/data contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (wr_en) begin
      vld[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_addr[InstAddrBus-1:IcIdxW+2];
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit instruction from four byte reads on a
// granted byte-wide bus. Optional instruction cache under IF_ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  if_fetch_if.master             mem,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid
);

  logic [2:0]             state;
  logic [InstAddrBus-1:0] pc;
  logic                   pend;
  logic [1:0]             pend_lane;
  logic [1:0]             lane;
  logic                   issue;
  logic                   ic_hit;
  logic [InstBus-1:0]     ic_word;
  logic [InstBus-1:0]     cap_word;

  assign lane     = state[1:0];
  assign cap_word = put_lane(if_inst, pend_lane, mem.mem_din_i);

`ifdef IF_ICACHE_EN
  logic ic_we;

  // The entry is filled as the last byte lands, i.e. on entry to DONE after a miss.
  assign ic_we = !rst && !branch_flag_i && (state == DONE) && !if_valid && pend;

  if_icache u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (pc[InstAddrBus-1:2]),
    .rd_hit  (ic_hit),
    .rd_data (ic_word),
    .wr_en   (ic_we),
    .wr_addr (pc[InstAddrBus-1:2]),
    .wr_data (cap_word)
  );
`else
  assign ic_hit  = 1'b0;
  assign ic_word = ZeroWord;
`endif

  assign issue = !rst && !branch_flag_i && (state != DONE) && mem.mem_grant_i
               && !((state == B0) && ic_hit);

  assign mem.mem_rd_o = issue;
  assign mem.mem_a_o  = issue ? pc + {30'd0, lane} : ZeroWord;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= B0;
      pc        <= ZeroWord;
      pend      <= 1'b0;
      pend_lane <= 2'd0;
      if_pc     <= ZeroWord;
      if_inst   <= ZeroWord;
      if_valid  <= 1'b0;
    end else if (branch_flag_i) begin
      pc       <= branch_target_i;
      state    <= B0;
      if_valid <= 1'b0;
      pend     <= 1'b0;
    end else begin
      pend      <= issue;
      pend_lane <= lane;
      if (pend) begin
        if_inst <= cap_word;
      end
      case (state)
        B0: begin
          if (ic_hit) begin
            if_inst  <= ic_word;
            if_pc    <= pc;
            if_valid <= 1'b1;
            state    <= DONE;
          end else if (issue) begin
            state <= B1;
          end
        end
        B1: if (issue) state <= B2;
        B2: if (issue) state <= B3;
        B3: if (issue) state <= DONE;
        DONE: begin
          // First DONE cycle after a miss still collects byte 3; valid follows it.
          if (if_valid) begin
            if (!stall_i) begin
              pc       <= pc + 32'd4;
              state    <= B0;
              if_valid <= 1'b0;
            end
          end else if (pend) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
          end
        end
        default: state <= B0;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed fetch sequences against a byte memory
// model; cache-specific checks are compiled in with IF_ICACHE_EN.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        grant;
  logic [7:0]  din;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  if_fetch_if mem ();
  assign mem.mem_grant_i = grant;
  assign mem.mem_din_i   = din;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem             (mem),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  memarr [1024];
  logic        last_rd;
  logic [31:0] last_a;

  // Synchronous byte memory: the byte for an address seen this cycle appears next cycle.
  always @(negedge clk) begin
    last_rd = mem.mem_rd_o;
    last_a  = mem.mem_a_o;
  end

  always @(posedge clk) begin
    #1;
    din = last_rd ? memarr[last_a[9:0]] : 8'hee;
  end

  always @(negedge clk) begin
    if (!rst && if_valid && !stall_i && !branch_flag_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no delivery", if_pc, if_inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          errors++;
          $display("FAIL sb_deliver: got pc=%h inst=%h, required pc=%h inst=%h",
                   if_pc, if_inst, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic nsamp;
    @(negedge clk);
  endtask

  task automatic put_word(input int unsigned a, input logic [31:0] w);
    memarr[a]   = w[31:24];
    memarr[a+1] = w[23:16];
    memarr[a+2] = w[15:8];
    memarr[a+3] = w[7:0];
  endtask

  // Entered at the start of a B0 cycle; returns at the sample point of the valid cycle.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] inst, input bit push);
    if (push) sb.push_back({pc, inst});
    for (int unsigned k = 0; k < 4; k++) begin
      nsamp;
      if (k == 0) chk($sformatf("idle_valid@%h", pc), {31'd0, if_valid}, 32'd0);
      chk($sformatf("rd%0d@%h", k, pc), {31'd0, mem.mem_rd_o}, 32'd1);
      chk($sformatf("addr%0d@%h", k, pc), mem.mem_a_o, pc + k);
      step;
    end
    nsamp;
    chk($sformatf("early_valid@%h", pc), {31'd0, if_valid}, 32'd0);
    step;
    nsamp;
    chk($sformatf("lat5_valid@%h", pc), {31'd0, if_valid}, 32'd1);
    chk($sformatf("if_pc@%h", pc), if_pc, pc);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) memarr[i] = 8'h5a ^ i[7:0];
    put_word(32'h000, 32'h1305_0000);
    put_word(32'h004, 32'h9305_1000);
    put_word(32'h008, 32'haabb_ccdd);
    put_word(32'h00c, 32'h1122_3344);
    put_word(32'h040, 32'h0102_0304);
    put_word(32'h100, 32'hdead_beef);
    put_word(32'h104, 32'hcafe_babe);
    put_word(32'h200, 32'h5566_7788);
    put_word(32'h3fc, 32'h0f1e_2d3c);

    rst = 1'b1; grant = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0;
    branch_target_i = '0; din = 8'hee; last_rd = 1'b0; last_a = '0;
    repeat (3) step;
    nsamp;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_rd", {31'd0, mem.mem_rd_o}, 32'd0);
    chk("rst_addr", mem.mem_a_o, 32'd0);
    step; rst = 1'b0;

    // Plain fetch from 0, then pc=4 with grant withheld for two cycles in B2.
    do_fetch(32'h0, 32'h1305_0000, 1'b1);
    step;
    sb.push_back({32'h4, 32'h9305_1000});
    nsamp; chk("g_addr4", mem.mem_a_o, 32'h4);
    step;  nsamp; chk("g_addr5", mem.mem_a_o, 32'h5);
    step;  grant = 1'b0;
    nsamp; chk("g_noread0", {31'd0, mem.mem_rd_o}, 32'd0);
    step;
    nsamp; chk("g_noread1", {31'd0, mem.mem_rd_o}, 32'd0);
    step;  grant = 1'b1;
    nsamp; chk("g_addr6", mem.mem_a_o, 32'h6);
    step;  nsamp; chk("g_addr7", mem.mem_a_o, 32'h7);
    step;  nsamp; chk("g_early", {31'd0, if_valid}, 32'd0);
    step;  nsamp; chk("g_valid7", {31'd0, if_valid}, 32'd1);
    step;

    // Three stalled cycles in DONE, then a single pc advance.
    stall_i = 1'b1;
    do_fetch(32'h8, 32'haabb_ccdd, 1'b1);
    for (int unsigned s = 0; s < 2; s++) begin
      step; nsamp;
      chk($sformatf("st_valid%0d", s), {31'd0, if_valid}, 32'd1);
      chk($sformatf("st_pc%0d", s), if_pc, 32'h8);
      chk($sformatf("st_inst%0d", s), if_inst, 32'haabb_ccdd);
    end
    step; stall_i = 1'b0;
    nsamp; chk("st_release_valid", {31'd0, if_valid}, 32'd1);
    step;
    nsamp; chk("st_next_addr", mem.mem_a_o, 32'hc);

    // Branch while in B2 of the fetch at 0xc.
    step;  nsamp; chk("br_addr_d", mem.mem_a_o, 32'hd);
    step;  branch_flag_i = 1'b1; branch_target_i = 32'h100;
    nsamp; chk("br_valid", {31'd0, if_valid}, 32'd0);
    step;  branch_flag_i = 1'b0;
    do_fetch(32'h100, 32'hdead_beef, 1'b1);
    step;

    // Branch and stall together while the fetched word is presented.
    stall_i = 1'b1;
    do_fetch(32'h104, 32'hcafe_babe, 1'b0);
    step;  branch_flag_i = 1'b1; branch_target_i = 32'h200;
    nsamp; chk("bs_held_valid", {31'd0, if_valid}, 32'd1);
    chk("bs_held_pc", if_pc, 32'h104);
    step;  branch_flag_i = 1'b0; stall_i = 1'b0;
    do_fetch(32'h200, 32'h5566_7788, 1'b1);
    step;

    // Reset in the middle of a fetch; the returning byte must be dropped.
    nsamp; chk("mr_addr204", mem.mem_a_o, 32'h204);
    step;  nsamp; chk("mr_addr205", mem.mem_a_o, 32'h205);
    step;  rst = 1'b1;
    nsamp; chk("mr_rd", {31'd0, mem.mem_rd_o}, 32'd0);
    step;
    nsamp; chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_pc", if_pc, 32'd0);
    chk("mr_inst", if_inst, 32'd0);
    step;  rst = 1'b0;
    do_fetch(32'h0, 32'h1305_0000, 1'b1);
    step;

    // Unaligned-free top of address space: pc wraps to 0 after the last word.
    branch_flag_i = 1'b1; branch_target_i = 32'hffff_fffc;
    step;  branch_flag_i = 1'b0;
    do_fetch(32'hffff_fffc, 32'h0f1e_2d3c, 1'b1);
    step;

`ifdef IF_ICACHE_EN
    sb.push_back({32'h0, 32'h1305_0000});
    nsamp; chk("hit_rd", {31'd0, mem.mem_rd_o}, 32'd0);
    step;
    nsamp; chk("hit_lat1_valid", {31'd0, if_valid}, 32'd1);
    chk("hit_inst", if_inst, 32'h1305_0000);
    step;
    do_fetch(32'h4, 32'h9305_1000, 1'b1);
    step;  branch_flag_i = 1'b1; branch_target_i = 32'h40;
    step;  branch_flag_i = 1'b0;
    do_fetch(32'h40, 32'h0102_0304, 1'b1);
    step;  branch_flag_i = 1'b1; branch_target_i = 32'h0;
    step;  branch_flag_i = 1'b0;
    do_fetch(32'h0, 32'h1305_0000, 1'b1);
    step;
`else
    do_fetch(32'h0, 32'h1305_0000, 1'b1);
    step;
`endif

    repeat (2) step;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d undelivered, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit, the synchronous active-high reset.
REQ-003 The block SHALL have the port stall_i, input, 1 bit, which holds the delivered instruction and PC.
REQ-004 The block SHALL have the port branch_flag_i, input, 1 bit, which redirects fetch.
REQ-005 The block SHALL have the port branch_target_i, input, 32 bits, the redirect PC.
REQ-006 The block SHALL have the port mem_grant_i, input, 1 bit, which means the arbiter grants the byte-wide memory this cycle.
REQ-007 The block SHALL have the port mem_din_i, input, 8 bits, the read byte, valid the cycle after its address was issued.
REQ-008 The block SHALL have the port mem_rd_o, output, 1 bit, the read request.
REQ-009 The block SHALL have the port mem_a_o, output, 32 bits, the byte address.
REQ-010 The block SHALL have the port if_pc, output, 32 bits, the PC of the delivered instruction.
REQ-011 The block SHALL have the port if_inst, output, 32 bits, the instruction in memory byte order: [31:24]=byte@pc, [23:16]=pc+1, [15:8]=pc+2, [7:0]=pc+3.
REQ-012 The block SHALL have the port if_valid, output, 1 bit, which means if_pc/if_inst are a valid instruction.

Function
REQ-013 The FSM SHALL have the states B0, B1, B2, B3 (issue byte k at pc+k) and DONE.
REQ-014 In Bk with mem_grant_i=1, the block SHALL drive mem_rd_o=1 and mem_a_o=pc+k, then advance; with mem_grant_i=0 it SHALL hold the state with mem_rd_o=0.
REQ-015 The block SHALL capture mem_din_i in the cycle after every issued read, regardless of the current grant, into the byte lane given in REQ-011.
REQ-016 On entry to DONE, all 4 bytes SHALL be captured; if_valid=1 and if_pc=pc.
REQ-017 In DONE with stall_i=0, the block SHALL set pc<=pc+4 (32-bit wrap) and go to B0; if_valid SHALL be 1 for exactly that cycle.
REQ-018 In DONE with stall_i=1, the block SHALL hold if_valid, if_pc and if_inst unchanged.
REQ-019 Uncached latency SHALL be 5 cycles from B0 to valid with continuous grant.
REQ-020 branch_flag_i=1 in any state SHALL set pc<=branch_target_i and state<=B0, set if_valid<=0, and discard any in-flight byte.
REQ-021 Branch SHALL win over stall_i when both are asserted in the same cycle.
REQ-022 The block SHALL not check branch_target_i alignment; it SHALL fetch from the given address.

Reset
REQ-023 On rst=1, the block SHALL set pc=0, state=B0, if_pc=0, if_inst=0, if_valid=0, mem_rd_o=0, mem_a_o=0, and clear the pending-capture flag.
REQ-024 Reset mid-fetch SHALL abandon the fetch; a byte returning the next cycle SHALL be ignored.

Configuration
REQ-025 With IF_ICACHE_EN defined, the block SHALL include a 16-entry direct-mapped instruction cache: index pc[5:2], tag pc[31:6], one valid bit per entry.
REQ-026 With IF_ICACHE_EN, a hit in B0 SHALL skip memory (mem_rd_o=0) and enter DONE next cycle with the cached word (latency 1).
REQ-027 With IF_ICACHE_EN, a miss SHALL proceed as in REQ-014, and the entry SHALL be written on entry to DONE.
REQ-028 With IF_ICACHE_EN, reset SHALL clear all valid bits, and there SHALL be no other invalidation.
REQ-029 Without IF_ICACHE_EN, the block SHALL contain no cache storage and have 5-cycle latency always.

Structure
REQ-030 The state encodings, the ZeroWord constant, bus-width macros (InstAddrBus, InstBus) and the cache geometry constants SHALL live in define.v.
REQ-031 The cache SHALL be the sub-module if_icache, with a combinational lookup port and a synchronous write port; it is instantiated only under IF_ICACHE_EN.

Verification
REQ-032 The bench SHALL check: reset, then grant=1 and memory 0x00..0x03 = 13 05 00 00 -> mem_a_o 0,1,2,3 on consecutive cycles; cycle 5 has if_valid=1, if_pc=0, if_inst=0x13050000; next pc=4.
REQ-033 The bench SHALL check: grant=0 for 2 cycles in B2 -> no read, state held, valid on cycle 7, if_inst still correct.
REQ-034 The bench SHALL check: stall_i=1 for 3 cycles in DONE -> if_valid, if_pc and if_inst constant; after release, pc advances by 4 exactly once.
REQ-035 The bench SHALL check: branch_flag_i=1 in B2 with target 0x100 -> if_valid=0, next issue mem_a_o=0x100, and the old byte is not merged into the new instruction.
REQ-036 The bench SHALL check: branch and stall together in DONE -> branch is taken and pc=target.
REQ-037 With IF_ICACHE_EN, the bench SHALL check: loop branching back to 0x0 -> first fetch takes 5 cycles, the refetch takes 1 cycle with mem_rd_o=0, and 0x40 evicts 0x0 (same index).
